ring_counter_param: RTL
=======================

Name: ring_counter_param

Overview:
- Parametrised shift-register counter; successor to the fixed 4-bit one-hot ring counter.
- Adds the following over the fixed counter:
  - WIDTH parameter
  - selectable ring (one-hot) or Johnson (twisted-ring) mode
  - rotate direction, count enable and parallel load
  - illegal-state detection with self-correction
  - wrap pulse
- Used as sequencer / phase generator for multi-step datapath control in the team's teaching designs.

Parameters:
WIDTH, 4, state register width; legal range 2..32.
INIT_POS, 0, bit index set in the ring home pattern; 0..WIDTH-1.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately, independent of clk.
en  input  1  count enable; 1 = advance one step per rising edge.
mode  input  1  0 = ring (one-hot rotate), 1 = Johnson (inverted feedback).
dir  input  1  0 = shift toward LSB (bit0 wraps into MSB), 1 = shift toward MSB (MSB wraps into bit0).
load  input  1  synchronous parallel load strobe.
load_val  input  WIDTH  value loaded when load=1.
count_out  output  WIDTH  registered counter state.
wrap  output  1  registered one-cycle pulse on return to home.
illegal  output  1  combinational flag: count_out not a legal state for current mode.

Behaviour:
- Reset (reset=0, asynchronous): count_out = one-hot at INIT_POS, wrap = 0. Held while reset=0. Release takes effect at the next rising edge.
- Home pattern:
  - ring: one-hot at INIT_POS.
  - Johnson: all zeros.
- Next-state priority at each rising edge (reset=1):
  1. load=1: count_out <= load_val, regardless of en or legality; wrap <= 0.
  2. else en=1 and illegal=1: count_out <= home of current mode; wrap <= 0.
  3. else en=1: shift one step (rules below).
  4. else: hold count_out; wrap <= 0.
- Ring shift:
  - dir=0: bit[i] <= bit[i+1], bit[WIDTH-1] <= bit[0].
  - dir=1: bit[i+1] <= bit[i], bit[0] <= bit[WIDTH-1].
- Johnson shift: same as ring shift, except the wrapped-in bit is inverted.
  - dir=0: bit[WIDTH-1] <= ~bit[0].
  - dir=1: bit[0] <= ~bit[WIDTH-1].
- Period: WIDTH steps in ring mode; 2*WIDTH steps in Johnson mode.
- wrap: set to 1 at an edge where a shift (case 3) produces the home pattern of the current mode; 0 at every other edge. Load and correction never raise wrap.
- illegal decode (combinational on count_out and mode):
  - ring: popcount(count_out) != 1.
  - Johnson: number of positions i where bit[i] != bit[(i+1) mod WIDTH] (circular) exceeds 2.
- Mode change: no special handling. The state is kept; if it is illegal in the new mode, correction applies on the next enabled edge. A one-hot pattern is a legal Johnson state.
- dir change takes effect at the next shift; no correction involved.
- en=0 with illegal=1: state held, illegal stays high; no correction until en=1.
- No combinational path from inputs to count_out or wrap.

Test Plan:
1. WIDTH=4, INIT_POS=0; reset pulse, then en=1, mode=0, dir=0 for 4 edges:
   - count_out = 1000, 0100, 0010, 0001.
   - wrap=1 only while 0001; illegal=0 throughout.
2. From 0001, dir=1, mode=0, en=1, 4 edges:
   - count_out = 0010, 0100, 1000, 0001; wrap pulses on 0001.
3. Load 0000, mode=1, dir=0, en=1, 8 edges:
   - count_out = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
   - wrap=1 only on final 0000; no wrap on the load edge.
4. mode=0, load=1 with load_val=1010:
   - count_out=1010, illegal=1.
   - en=0 for 3 edges: holds 1010.
   - en=1 edge: count_out=0001, illegal=0, wrap=0.
5. Async reset mid-count:
   - While counting at 0100, drop reset between edges: count_out=0001 and wrap=0 immediately, without a clock edge.
   - Hold reset=0 over 2 edges: no change.
   - Release reset with en=1: next edge gives 1000.
6. Simultaneous load=1, en=1, load_val=0100 while state is 0010:
   - count_out=0100 (load wins), wrap=0.
   - Next en edge gives 0010.

Source files
------------

// File: rtl/ring_counter_param.sv
// Parametrised shift-register counter: one-hot ring or Johnson sequence, with direction, load,
// illegal-state self-correction and a wrap pulse on return to the home pattern.
module ring_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned INIT_POS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap,
  output logic             illegal
);

  localparam int unsigned CNT_W = 6;
  localparam logic [WIDTH-1:0] HOME_RING = WIDTH'(1) << INIT_POS;

  if (WIDTH < 2 || WIDTH > 32 || INIT_POS >= WIDTH) begin : g_param_check
    $error("ring_counter_param: WIDTH must be 2..32 and INIT_POS below WIDTH");
  end

  logic [CNT_W-1:0] ones_c;
  logic [CNT_W-1:0] edges_c;
  logic [WIDTH-1:0] home_c;
  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] next_q;
  logic             next_wrap;

  // Ring states have exactly one set bit; Johnson states have at most two circular 0/1 boundaries.
  always_comb begin : illegal_decode
    ones_c  = '0;
    edges_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones_c = ones_c + CNT_W'(count_out[i]);
    end
    for (int unsigned i = 0; i < WIDTH - 1; i++) begin
      edges_c = edges_c + CNT_W'(count_out[i] ^ count_out[i+1]);
    end
    edges_c = edges_c + CNT_W'(count_out[WIDTH-1] ^ count_out[0]);
    illegal = mode ? (edges_c > CNT_W'(2)) : (ones_c != CNT_W'(1));
  end

  // One rotate step; Johnson mode inverts the bit that wraps around.
  always_comb begin : shift_step
    home_c = mode ? '0 : HOME_RING;
    if (dir) begin
      shifted_c = {count_out[WIDTH-2:0], count_out[WIDTH-1] ^ mode};
    end else begin
      shifted_c = {count_out[0] ^ mode, count_out[WIDTH-1:1]};
    end
  end

  // Priority: load, then correction of an illegal state, then shift, else hold.
  always_comb begin : next_state
    next_q    = count_out;
    next_wrap = 1'b0;
    if (load) begin
      next_q = load_val;
    end else if (en && illegal) begin
      next_q = home_c;
    end else if (en) begin
      next_q    = shifted_c;
      next_wrap = (shifted_c == home_c);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_out <= HOME_RING;
      wrap      <= 1'b0;
    end else begin
      count_out <= next_q;
      wrap      <= next_wrap;
    end
  end

endmodule
